// File: rtl/if_fetch_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry FIFO of {PC, Instruction} pairs
// with decode-side freeze, whole-queue flush and a zero bubble when empty.
module if_fetch_queue #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     Flush,
  input  logic                     Freeze,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [PC_W-1:0]          PC_in,
  input  logic [INST_W-1:0]        Instruction_in,
  output logic                     valid,
  output logic [PC_W-1:0]          PC,
  output logic [INST_W-1:0]        Instruction,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = PC_W + INST_W;

  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [ENTRY_W-1:0] head;
  logic               push;
  logic               pop;

  // Handshake derives from occupancy only, so a full queue never passes a push through a pop.
  assign push_ready = (count_q != CNT_W'(DEPTH));
  assign valid      = (count_q != '0);
  assign push       = push_valid & push_ready;
  assign pop        = valid & ~Freeze;

  assign head        = mem_q[rd_ptr_q];
  assign PC          = valid ? head[ENTRY_W-1:INST_W] : '0;
  assign Instruction = valid ? head[INST_W-1:0]       : '0;
  assign count       = count_q;

  // Next-state: flush discards everything, including a same-cycle push or pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (Flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push && !rst) begin
        mem_d[wr_ptr_q] = {PC_in, Instruction_in};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; stale data is hidden by the valid mask.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
